// File: rtl/fifo_unpack.sv
// Unpacks 36-bit FWFT FIFO words (32 data bits + 4 byte enables) into a
// byte stream, lowest enabled byte first, dropping disabled bytes.
module fifo_unpack (
  input  logic        CLK,
  input  logic        RST,
  input  logic [35:0] FIFO_DO,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RDEN,
  output logic [7:0]  BYTE,
  output logic        VALID,
  input  logic        READY,
  output logic [31:0] COUNT
);

  logic [31:0] hold;
  logic [3:0]  pend;
  logic [31:0] count;
  logic        take;
  logic        last;
  logic [1:0]  sel;

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] clr_low(input logic [3:0] m);
    return m & (m - 4'd1);
  endfunction

  function automatic logic one_hot(input logic [3:0] m);
    return (m != 4'd0) && (clr_low(m) == 4'd0);
  endfunction

  // Output/handshake stage: byte select and pop decision from current state
  assign VALID     = (pend != 4'd0);
  assign take      = VALID && READY;
  assign last      = take && one_hot(pend);
  assign FIFO_RDEN = !RST && !FIFO_EMPTY && ((pend == 4'd0) || last);
  assign sel       = low_idx(pend);
  assign BYTE      = hold[{sel, 3'b000} +: 8];
  assign COUNT     = count;

  // State stage: a new word overrides the clear of the final pending bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold  <= '0;
      pend  <= '0;
      count <= '0;
    end else begin
      if (take) begin
        count <= count + 32'd1;
      end
      if (FIFO_RDEN) begin
        hold <= FIFO_DO[31:0];
        pend <= FIFO_DO[35:32];
      end else if (take) begin
        pend <= clr_low(pend);
      end
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// Scoreboard bench for fifo_unpack: a queue-based FWFT FIFO model feeds the
// DUT and every enabled byte pushed is expected back in order.
module tb_fifo_unpack;
  logic        CLK = 1'b0;
  logic        RST;
  logic [35:0] FIFO_DO;
  logic        FIFO_EMPTY;
  logic        FIFO_RDEN;
  logic [7:0]  BYTE;
  logic        VALID;
  logic        READY;
  logic [31:0] COUNT;

  logic [35:0] fq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  e;
  logic        rden_s = 1'b0;
  logic        pop_now;
  logic [31:0] exp_cnt;
  logic [31:0] r;
  int checks = 0, passed = 0, pops = 0;
  int ntake, first_t, last_t, p0, nrd, first_r, last_r, took;

  fifo_unpack dut (
    .CLK(CLK), .RST(RST), .FIFO_DO(FIFO_DO), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RDEN(FIFO_RDEN), .BYTE(BYTE), .VALID(VALID), .READY(READY),
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic void refresh();
    FIFO_EMPTY = (fq.size() == 0);
    FIFO_DO    = (fq.size() != 0) ? fq[0] : 36'h0;
  endfunction

  task automatic push_word(input logic [35:0] w);
    fq.push_back(w);
    for (int i = 0; i < 4; i++) if (w[32+i]) exp_q.push_back(w[8*i +: 8]);
    refresh();
  endtask

  // FIFO model: pop after the edge at which the DUT sampled the head word
  always @(negedge CLK) rden_s = FIFO_RDEN;
  always @(posedge CLK) begin
    pop_now = rden_s;
    #1;
    if (pop_now && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    refresh();
  end

  task automatic test_reset();
    push_word(36'hF_44332211);
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (FIFO_RDEN !== 1'b0 || VALID !== 1'b0 || COUNT !== 32'd0)
        $display("FAIL rst_hold: rden=%b valid=%b count=%h required 0,0,0", FIFO_RDEN, VALID, COUNT);
      else passed++;
    end
    @(posedge CLK); #2; RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (FIFO_RDEN !== 1'b1 || VALID !== 1'b0)
      $display("FAIL rst_first_rden: rden=%b valid=%b required 1,0", FIFO_RDEN, VALID);
    else passed++;
    @(posedge CLK); #2;
    @(negedge CLK);
    checks++;
    if (VALID !== 1'b1 || BYTE !== 8'h11)
      $display("FAIL rst_valid_next: valid=%b byte=%h required 1,11", VALID, BYTE);
    else passed++;
    @(posedge CLK); #2; READY = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rst_byte: got %h required none", BYTE);
        else begin
          e = exp_q.pop_front();
          if (BYTE !== e) $display("FAIL rst_byte: got %h required %h", BYTE, e);
          else passed++;
        end
      end
      @(posedge CLK); #2;
    end
    exp_cnt = 32'd4;
  endtask

  task automatic test_full_word();
    p0 = pops; ntake = 0; first_t = -1; last_t = -1;
    push_word(36'hF_44332211);
    for (int c = 0; c < 20 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL full_byte: got %h required none", BYTE);
        else begin
          e = exp_q.pop_front();
          if (BYTE !== e) $display("FAIL full_byte: got %h required %h", BYTE, e);
          else passed++;
        end
        if (first_t < 0) first_t = c;
        last_t = c; ntake++;
      end
      @(posedge CLK); #2;
    end
    exp_cnt = exp_cnt + 32'd4;
    @(negedge CLK);
    checks++;
    if (ntake !== 4 || last_t - first_t !== 3 || pops - p0 !== 1 || COUNT !== exp_cnt)
      $display("FAIL full_shape: takes=%0d span=%0d pops=%0d count=%0d required 4,3,1,%0d",
               ntake, last_t - first_t, pops - p0, COUNT, exp_cnt);
    else passed++;
    @(posedge CLK); #2;
  endtask

  task automatic test_sparse();
    p0 = pops; ntake = 0; first_t = -1; last_t = -1;
    push_word(36'h5_DDCCBBAA);
    push_word(36'h0_12345678);
    push_word(36'h8_EE000000);
    for (int c = 0; c < 20 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL sparse_byte: got %h required none", BYTE);
        else begin
          e = exp_q.pop_front();
          if (BYTE !== e) $display("FAIL sparse_byte: got %h required %h", BYTE, e);
          else passed++;
        end
        if (first_t < 0) first_t = c;
        last_t = c; ntake++;
      end
      @(posedge CLK); #2;
    end
    exp_cnt = exp_cnt + 32'd3;
    @(negedge CLK);
    checks++;
    if (ntake !== 3 || last_t - first_t !== 3 || pops - p0 !== 3 || COUNT !== exp_cnt)
      $display("FAIL sparse_shape: takes=%0d span=%0d pops=%0d count=%0d required 3,3,3,%0d",
               ntake, last_t - first_t, pops - p0, COUNT, exp_cnt);
    else passed++;
    @(posedge CLK); #2;
  endtask

  task automatic test_backpressure();
    took = 0;
    push_word(36'hF_04030201);
    for (int c = 0; c < 20 && took < 2; c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        e = exp_q.pop_front();
        if (BYTE !== e) $display("FAIL bp_byte: got %h required %h", BYTE, e);
        else passed++;
        took++;
      end
      @(posedge CLK); #2;
    end
    READY = 1'b0; p0 = pops;
    exp_cnt = exp_cnt + 32'd2;
    repeat (10) begin
      @(negedge CLK);
      checks++;
      if (VALID !== 1'b1 || BYTE !== 8'h03 || FIFO_RDEN !== 1'b0 || COUNT !== exp_cnt)
        $display("FAIL bp_hold: valid=%b byte=%h rden=%b count=%0d required 1,03,0,%0d",
                 VALID, BYTE, FIFO_RDEN, COUNT, exp_cnt);
      else passed++;
      @(posedge CLK); #2;
    end
    checks++;
    if (pops !== p0) $display("FAIL bp_nopop: pops=%0d required %0d", pops, p0);
    else passed++;
    READY = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp_byte: got %h required none", BYTE);
        else begin
          e = exp_q.pop_front();
          if (BYTE !== e) $display("FAIL bp_byte: got %h required %h", BYTE, e);
          else passed++;
        end
      end
      @(posedge CLK); #2;
    end
    exp_cnt = exp_cnt + 32'd2;
  endtask

  task automatic test_back_to_back();
    ntake = 0; first_t = -1; last_t = -1; nrd = 0; first_r = -1; last_r = -1;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      push_word({4'h1, r});
    end
    for (int c = 0; c < 60 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (FIFO_RDEN) begin
        if (first_r < 0) first_r = c;
        last_r = c; nrd++;
      end
      if (VALID && READY) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_byte: got %h required none", BYTE);
        else begin
          e = exp_q.pop_front();
          if (BYTE !== e) $display("FAIL b2b_byte: got %h required %h", BYTE, e);
          else passed++;
        end
        if (first_t < 0) first_t = c;
        last_t = c; ntake++;
      end
      @(posedge CLK); #2;
    end
    exp_cnt = exp_cnt + 32'd16;
    @(negedge CLK);
    checks++;
    if (ntake !== 16 || last_t - first_t !== 15 || nrd !== 16 || last_r - first_r !== 15
        || COUNT !== exp_cnt)
      $display("FAIL b2b_shape: takes=%0d span=%0d rdens=%0d rspan=%0d count=%0d required 16,15,16,15,%0d",
               ntake, last_t - first_t, nrd, last_r - first_r, COUNT, exp_cnt);
    else passed++;
    @(posedge CLK); #2;
  endtask

  task automatic test_wrap();
    READY = 1'b0;
    force dut.count = 32'hFFFF_FFFF;
    @(negedge CLK);
    @(posedge CLK); #2;
    release dut.count;
    @(negedge CLK);
    checks++;
    if (COUNT !== 32'hFFFF_FFFF) $display("FAIL wrap_preset: count=%h required ffffffff", COUNT);
    else passed++;
    @(posedge CLK); #2;
    push_word(36'h1_000000A5);
    READY = 1'b1;
    for (int c = 0; c < 10 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        e = exp_q.pop_front();
        if (BYTE !== e) $display("FAIL wrap_byte: got %h required %h", BYTE, e);
        else passed++;
      end
      @(posedge CLK); #2;
    end
    exp_cnt = 32'd0;
    @(negedge CLK);
    checks++;
    if (COUNT !== exp_cnt) $display("FAIL wrap_count: count=%h required 0", COUNT);
    else passed++;
    @(posedge CLK); #2;
  endtask

  task automatic test_reset_midword();
    took = 0;
    push_word(36'hF_88776655);
    for (int c = 0; c < 10 && took < 1; c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        e = exp_q.pop_front();
        if (BYTE !== e) $display("FAIL mid_byte: got %h required %h", BYTE, e);
        else passed++;
        took++;
      end
      @(posedge CLK); #2;
    end
    RST = 1'b1;
    exp_q.delete();
    p0 = pops;
    #1;
    checks++;
    if (VALID !== 1'b0 || FIFO_RDEN !== 1'b0 || COUNT !== 32'd0)
      $display("FAIL mid_rst_now: valid=%b rden=%b count=%h required 0,0,0", VALID, FIFO_RDEN, COUNT);
    else passed++;
    repeat (2) @(posedge CLK);
    #2; RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (VALID !== 1'b0 || pops !== p0)
        $display("FAIL mid_idle: valid=%b pops=%0d required 0,%0d", VALID, pops, p0);
      else passed++;
      @(posedge CLK); #2;
    end
    push_word(36'h1_000000C3);
    for (int c = 0; c < 10 && (exp_q.size() != 0 || fq.size() != 0); c++) begin
      @(negedge CLK);
      if (VALID && READY) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL mid_after: got %h required none", BYTE);
        else begin
          e = exp_q.pop_front();
          if (BYTE !== e) $display("FAIL mid_after: got %h required %h", BYTE, e);
          else passed++;
        end
      end
      @(posedge CLK); #2;
    end
    @(negedge CLK);
    checks++;
    if (COUNT !== 32'd1 || VALID !== 1'b0)
      $display("FAIL mid_count: count=%0d valid=%b required 1,0", COUNT, VALID);
    else passed++;
  endtask

  initial begin
    RST = 1'b1;
    READY = 1'b0;
    exp_cnt = 32'd0;
    refresh();
    test_reset();
    test_full_word();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_midword();
    checks++;
    if (exp_q.size() != 0 || fq.size() != 0)
      $display("FAIL drained: bytes_left=%0d words_left=%0d required 0,0", exp_q.size(), fq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_unpack.md
# fifo_unpack

Read-side consumer for the 36-bit first-word-fall-through output FIFO. It pops words (32 data bits plus 4 per-byte enable bits) from the FIFO read port and emits them as a byte stream with a valid/ready handshake. Bytes whose enable bit is clear are dropped, and words with no enabled bytes are discarded. It sits in the read clock domain, between the FIFO's DO/EMPTY/RDEN port and the byte-wide downstream link.

## Interface
Parameters: none.

Ports:
- CLK  input  1  single clock; the FIFO read clock. All state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- FIFO_DO  input  36  head word of the FWFT FIFO. [31:0] is data, byte i = [8i+7:8i]. [35:32] is the enable mask, bit 32+i enables byte i.
- FIFO_EMPTY  input  1  FIFO empty; FIFO_DO is valid when low.
- FIFO_RDEN  output  1  pop strobe; combinational.
- BYTE  output  8  current output byte.
- VALID  output  1  BYTE is valid.
- READY  input  1  downstream accepts BYTE this cycle.
- COUNT  output  32  bytes delivered since reset.

## Operation
- State:
  - hold[31:0]: data register.
  - pend[3:0]: pending-byte mask.
  - count[31:0]: delivered-byte counter.
- Output path:
  - VALID = (pend != 0).
  - BYTE = the hold byte at the lowest set bit of pend. Bytes go out in ascending order, byte 0 first.
  - BYTE is a don't-care when VALID is low.
- Acceptance:
  - take = VALID && READY.
  - On take, the lowest set bit of pend is cleared and count increments by 1.
- Load:
  - last = pend has exactly one bit set and take is high.
  - FIFO_RDEN = !RST && !FIFO_EMPTY && (pend == 0 || last).
  - When FIFO_RDEN is high, at the same edge hold <= FIFO_DO[31:0] and pend <= FIFO_DO[35:32].
  - The load takes priority over the bit-clear from the last take. Net effect: the old word finishes and the new word is installed.
- Zero-mask words: a word with FIFO_DO[35:32] == 0 is popped and leaves pend == 0. The next cycle pops again if the FIFO is non-empty. Each such word costs one idle cycle and produces no output.
- FIFO_RDEN is never asserted while FIFO_EMPTY is high. Underflow is impossible by construction.
- VALID/BYTE hold stable while VALID && !READY (AXI-style). The block never withdraws VALID without a take.
- count wraps modulo 2^32 with no saturation. COUNT = count, registered.
- Reset:
  - RST high clears pend (VALID = 0), clears hold, clears count (COUNT = 0), and forces FIFO_RDEN low immediately.
  - On deassertion the block is idle and loads on the first cycle the FIFO is non-empty.
  - Reset mid-word discards the remaining pending bytes; the FIFO is not popped for them.

## Timing
- Latency:
  - Block idle (pend == 0) and FIFO_EMPTY falls in cycle N: FIFO_RDEN is high in cycle N, and VALID with the first enabled byte is high in cycle N+1.
  - Zero-mask words ahead of the first useful word add 1 cycle each.
- Throughput:
  - With READY held high, one byte per cycle and no bubbles between consecutive words. The pop for word k+1 occurs in the cycle the last byte of word k is taken.
  - Single-enabled-byte words stream at one word per cycle.
- Handshake: downstream may hold READY low indefinitely. pend, hold and count do not change and FIFO_RDEN stays low.
- Simultaneous events:
  - Last take and a non-empty FIFO in the same cycle: pop plus reload, VALID stays high.
  - Last take and an empty FIFO: VALID falls next cycle.
- Only FIFO_RDEN and BYTE are combinational outputs. VALID and COUNT are straight from registers or a reduction of registers.

## Test plan
- Reset values: assert RST with a non-empty FIFO -> FIFO_RDEN = 0, VALID = 0, COUNT = 0 throughout. Release -> FIFO_RDEN = 1 in the first cycle, VALID = 1 next.
- Full word, READY = 1: FIFO word 0xF_44332211 -> FIFO_RDEN pulses once, BYTE = 11, 22, 33, 44 on 4 consecutive cycles, COUNT = 4.
- Sparse masks:
  - Words 0x5_DDCCBBAA, then 0x0_12345678, then 0x8_EE000000.
  - Required BYTE sequence: AA, CC, then one idle cycle, then EE.
  - Exactly 3 pops; COUNT = 3.
- Backpressure: READY low for 10 cycles mid-word after the 2nd byte of 0xF_04030201 -> BYTE = 03 held for 10 cycles, VALID stays high, no pop, COUNT stays at 2. After release, 03 then 04.
- Back-to-back: 16 words each with mask 0x1, READY = 1 -> 16 bytes on 16 consecutive cycles, FIFO_RDEN high on 16 consecutive cycles, no VALID gaps.
- Wrap and reset mid-word:
  - Force count = 0xFFFFFFFF, then accept one byte -> COUNT = 0.
  - Assert RST after 1 of 4 bytes -> VALID = 0 immediately and the remaining 3 bytes are never emitted.
